// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub opcode encoding and
// the WIDTH-generic signed saturation limit.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int SAT_MAXW = 128;

    // Low w bits hold the signed min (neg=1) or max (neg=0) of a w-bit word.
    function automatic logic [SAT_MAXW-1:0] sat_limit(
        input logic neg,
        input int   w
    );
        logic [SAT_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_MAXW; i++) begin
            if (i < w - 1) begin
                r[i] = ~neg;
            end else if (i == w - 1) begin
                r[i] = neg;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple adder slice.
// One instance resolves one slice per pipeline stage.
module add_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub, one carry slice per stage, valid/ready.
// Optional signed clamp via PIPE_ADD_SUB_SAT_EN.
module pipe_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
`ifdef PIPE_ADD_SUB_SAT_EN
    input  logic             Sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int L      = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("pipe_add_sub: WIDTH must be a multiple of SLICE");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] en;

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             vin [STAGES];

`ifdef PIPE_ADD_SUB_SAT_EN
    logic sat_q [STAGES];
    logic sat_d [STAGES];
`endif

    logic             ovf_q;
    logic             zero_q;
    logic             ovf_f;
    logic [WIDTH-1:0] sum_f;

    // Bubble-collapsing chain: a stage moves if the next is empty or moving.
    always_comb begin
        adv    = '0;
        adv[L] = v[L] & out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
        en = ~v | adv;
    end

    assign in_ready = rst_n & en[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic [WIDTH-1:0] s_m;
        logic             c_i;
        logic [SLICE-1:0] sl_s;
        logic             sl_co;

        if (k == 0) begin : g_in
            assign a_i    = A;
            assign b_i    = (Sub == OP_SUB) ? ~B : B;
            assign c_i    = (Sub == OP_SUB) ? ~Cin : Cin;
            assign s_i    = '0;
            assign vin[k] = in_valid;
`ifdef PIPE_ADD_SUB_SAT_EN
            assign sat_d[k] = Sat;
`endif
        end else begin : g_fwd
            assign a_i    = a_q[k-1];
            assign b_i    = b_q[k-1];
            assign c_i    = c_q[k-1];
            assign s_i    = s_q[k-1];
            assign vin[k] = v[k-1];
`ifdef PIPE_ADD_SUB_SAT_EN
            assign sat_d[k] = sat_q[k-1];
`endif
        end

        add_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a (a_i[k*SLICE +: SLICE]),
            .b (b_i[k*SLICE +: SLICE]),
            .ci(c_i),
            .s (sl_s),
            .co(sl_co)
        );

        always_comb begin
            s_m                    = s_i;
            s_m[k*SLICE +: SLICE]  = sl_s;
        end

        assign a_d[k] = a_i;
        assign b_d[k] = b_i;
        assign s_d[k] = s_m;
        assign c_d[k] = sl_co;
    end

    // Carry into the MSB is recovered from the MSB sum bit itself.
    assign ovf_f = a_d[L][MSB] ^ b_d[L][MSB] ^ s_d[L][MSB] ^ c_d[L];

`ifdef PIPE_ADD_SUB_SAT_EN
    logic [SAT_MAXW-1:0] lim;
    assign lim = sat_limit(a_d[L][MSB], WIDTH);
`endif

    always_comb begin
        sum_f = s_d[L];
`ifdef PIPE_ADD_SUB_SAT_EN
        if (sat_d[L] && ovf_f) begin
            sum_f = lim[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v      <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
`ifdef PIPE_ADD_SUB_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k] <= vin[k];
                    if (vin[k]) begin
                        a_q[k] <= a_d[k];
                        b_q[k] <= b_d[k];
                        c_q[k] <= c_d[k];
                        s_q[k] <= (k == L) ? sum_f : s_d[k];
`ifdef PIPE_ADD_SUB_SAT_EN
                        sat_q[k] <= sat_d[k];
`endif
                    end
                end
            end
            if (en[L] && vin[L]) begin
                ovf_q  <= ovf_f;
                zero_q <= (sum_f == '0);
            end
        end
    end

    assign out_valid = v[L];
    assign Sum       = s_q[L];
    assign Cout      = c_q[L];
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: directed vectors, stream, stall,
// random backpressure and mid-flight reset.
module tb_pipe_add_sub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        Sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Sum;
    logic        Cout;
    logic        Ovf;
    logic        Zero;

    pipe_add_sub #(
        .WIDTH(32),
        .SLICE(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sub      (Sub),
`ifdef PIPE_ADD_SUB_SAT_EN
        .Sat      (sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum      (Sum),
        .Cout     (Cout),
        .Ovf      (Ovf),
        .Zero     (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } res_t;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   n_acc;
    res_t q[$];
    logic stalled;
    logic [31:0] h_sum;
    logic h_cout, h_ovf, h_zero;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic res_t golden(input logic [31:0] a,
                                    input logic [31:0] b,
                                    input logic ci, input logic sb,
                                    input logic st);
        res_t        r;
        logic [31:0] bb;
        logic [32:0] t;
        bb = sb ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? ~ci : ci)};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
`ifdef PIPE_ADD_SUB_SAT_EN
        if (st && r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (st) r.sum = r.sum;
`endif
        r.zero = (r.sum == 32'd0);
        r.cyc  = 0;
        return r;
    endfunction

    task automatic apply_vec(input vec_t t);
        int n;
        @(negedge clk);
        A = t.a; B = t.b; Cin = t.cin; Sub = t.sub; sat = t.sat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({t.name, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({t.name, " latency"}, n, 4);
        chk({t.name, " Sum"}, Sum, t.sum);
        chk({t.name, " Cout"}, Cout, t.cout);
        chk({t.name, " Ovf"}, Ovf, t.ovf);
        chk({t.name, " Zero"}, Zero, t.zero);
    endtask

    task automatic cycle(input logic rdy, input logic want,
                         input logic chk_lat);
        int   occ;
        res_t e;
        @(negedge clk);
        cyc++;
        if (stalled) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold Sum", Sum, h_sum);
            chk("hold flags", {Cout, Ovf, Zero}, {h_cout, h_ovf, h_zero});
        end
        out_ready = rdy;
        in_valid  = want;
        if (want) begin
            A   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            B   = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
            Cin = 1'($urandom_range(0, 1));
            Sub = 1'($urandom_range(0, 1));
`ifdef PIPE_ADD_SUB_SAT_EN
            sat = 1'($urandom_range(0, 1));
`else
            sat = 1'b0;
`endif
        end
        #1;
        occ = q.size();
        chk($sformatf("in_ready occ=%0d rdy=%0d", occ, rdy),
            in_ready, ((occ < 4) || rdy) ? 1 : 0);
        if (out_valid && rdy) begin
            if (q.size() == 0) begin
                chk("unexpected beat out_valid", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("stream Sum", Sum, e.sum);
                chk("stream flags", {Cout, Ovf, Zero},
                    {e.cout, e.ovf, e.zero});
                if (chk_lat) chk("stream latency", cyc - e.cyc, 4);
            end
        end
        if (want && in_ready) begin
            e = golden(A, B, Cin, Sub, sat);
            e.cyc = cyc;
            q.push_back(e);
            n_acc++;
        end
        stalled = out_valid && !rdy;
        h_sum = Sum; h_cout = Cout; h_ovf = Ovf; h_zero = Zero;
    endtask

    vec_t vt[$];

    function automatic vec_t mkv(input string nm, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci,
                                 input logic sb, input logic st,
                                 input logic [31:0] s, input logic co,
                                 input logic ov, input logic z);
        vec_t t;
        t.name = nm; t.a = a; t.b = b; t.cin = ci; t.sub = sb; t.sat = st;
        t.sum = s; t.cout = co; t.ovf = ov; t.zero = z;
        return t;
    endfunction

    initial begin
        int g;
        n_chk = 0; n_fail = 0; cyc = 0; n_acc = 0; stalled = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; sat = 1'b0;

        vt.push_back(mkv("wrap", 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1, 0, 1));
        vt.push_back(mkv("posovf", 32'h7FFF_FFFF, 1, 0, 0, 0,
                         32'h8000_0000, 0, 1, 0));
        vt.push_back(mkv("5m7", 5, 7, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0));
        vt.push_back(mkv("7m5m1", 7, 5, 1, 1, 0, 1, 1, 0, 0));
        vt.push_back(mkv("zero", 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv("negovf", 32'h8000_0000, 1, 0, 1, 0,
                         32'h7FFF_FFFF, 1, 1, 0));
        vt.push_back(mkv("cin", 32'h1234_5678, 32'h1111_1111, 1, 0, 0,
                         32'h2345_678A, 0, 0, 0));
        vt.push_back(mkv("eqsub", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 0,
                         0, 1, 0, 1));
        vt.push_back(mkv("slices", 32'h00FF_00FF, 32'h0001_0001, 0, 0, 0,
                         32'h0100_0100, 0, 0, 0));
        vt.push_back(mkv("minmin", 32'h8000_0000, 32'h8000_0000, 0, 0, 0,
                         0, 1, 1, 1));
`ifdef PIPE_ADD_SUB_SAT_EN
        vt.push_back(mkv("satmax", 32'h7FFF_FFFF, 1, 0, 0, 1,
                         32'h7FFF_FFFF, 0, 1, 0));
        vt.push_back(mkv("satmin", 32'h8000_0000, 32'h8000_0000, 0, 0, 1,
                         32'h8000_0000, 1, 1, 0));
        vt.push_back(mkv("satsub", 32'h8000_0000, 1, 0, 1, 1,
                         32'h8000_0000, 1, 1, 0));
        vt.push_back(mkv("satnop", 5, 7, 0, 0, 1, 12, 0, 0, 0));
`endif

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset Sum", Sum, 0);
        chk("reset flags", {Cout, Ovf, Zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1);

        foreach (vt[i]) apply_vec(vt[i]);

        for (int i = 0; i < 8; i++) cycle(1, 1, 1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1);
        chk("stream drained", q.size(), 0);

        for (int i = 0; i < 6; i++) cycle(0, 1, 0);
        chk("full occupancy", q.size(), 4);
        cycle(1, 1, 0);
        chk("accept+emit occupancy", q.size(), 4);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        chk("stall drained", q.size(), 0);

        n_acc = 0;
        g = 0;
        while (n_acc < 100 && g < 2000) begin
            cycle(1'($urandom_range(0, 1)), 1, 0);
            g++;
        end
        g = 0;
        while (q.size() > 0 && g < 100) begin
            cycle(1'($urandom_range(0, 1)), 0, 0);
            g++;
        end
        chk("random accepted", n_acc, 100);
        chk("random drained", q.size(), 0);

        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0);
        @(negedge clk);
        chk("pre-reset out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset Sum", Sum, 0);
        chk("midreset flags", {Cout, Ovf, Zero}, 0);
        chk("midreset in_ready", in_ready, 0);
        q.delete();
        stalled = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        chk("post-reset out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
